// File: rtl/lpgbt_fe_tx_gearbox.sv
// rtl/lpgbt_fe_tx_gearbox.sv - uplink TX gearbox, one frame per slot split into word_ce-paced words
module lpgbt_fe_tx_gearbox #(
    parameter int                FRAME_W   = 256,
    parameter int                WORD_W    = 32,
    parameter logic [WORD_W-1:0] IDLE_WORD = 32'hAAAA_AAAA
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [FRAME_W-1:0] frame_in,
    input  logic               frame_valid,
    output logic               frame_ready,
    input  logic               word_ce,
    output logic [WORD_W-1:0]  word_out,
    output logic               word_first,
    output logic               underrun,
    output logic               overrun
);

    localparam int RATIO = FRAME_W / WORD_W;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

    // Word position within the current slot; 0 means the next strobe starts a slot.
    logic [CNT_W-1:0]   cnt;
    // Single-entry holding buffer for a frame waiting for its slot.
    logic [FRAME_W-1:0] hold;
    logic               hold_full;
    // Remaining words of the frame currently being serialized, next word in the LSBs.
    logic [FRAME_W-1:0] sreg;

    logic accept;
    logic slot_start;
    logic start_from_hold;
    logic cut_through;

    // The buffer is the only backpressure point; nothing is accepted while in reset.
    assign frame_ready     = ~hold_full & ~reset;
    assign accept          = frame_valid & frame_ready;
    assign slot_start      = word_ce & (cnt == '0);
    assign start_from_hold = slot_start & hold_full;
    // A frame arriving exactly at an empty slot start bypasses the buffer.
    assign cut_through     = slot_start & ~hold_full & accept;

    // Holding buffer: filled by an accepted frame unless it cuts through, drained at slot start.
    always_ff @(posedge clock) begin
        if (reset) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (accept && !cut_through) begin
            hold      <= frame_in;
            hold_full <= 1'b1;
        end else if (start_from_hold) begin
            hold_full <= 1'b0;
        end
    end

    // Slot counter and shift register advance only on word strobes.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt  <= '0;
            sreg <= '0;
        end else if (word_ce) begin
            if (cnt == '0) begin
                if (hold_full) begin
                    sreg <= hold >> WORD_W;
                    cnt  <= CNT_W'(1);
                end else if (accept) begin
                    sreg <= frame_in >> WORD_W;
                    cnt  <= CNT_W'(1);
                end
            end else begin
                sreg <= sreg >> WORD_W;
                cnt  <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
            end
        end
    end

    // Registered word output; idle word fills slots that start with no frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            word_out   <= IDLE_WORD;
            word_first <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            word_first <= 1'b0;
            underrun   <= 1'b0;
            if (word_ce) begin
                if (cnt == '0) begin
                    if (hold_full) begin
                        word_out   <= hold[WORD_W-1:0];
                        word_first <= 1'b1;
                    end else if (accept) begin
                        word_out   <= frame_in[WORD_W-1:0];
                        word_first <= 1'b1;
                    end else begin
                        word_out <= IDLE_WORD;
                        underrun <= 1'b1;
                    end
                end else begin
                    word_out <= sreg[WORD_W-1:0];
                end
            end
        end
    end

    // A frame offered while the buffer is full is dropped and flagged one cycle later.
    always_ff @(posedge clock) begin
        if (reset) begin
            overrun <= 1'b0;
        end else begin
            overrun <= frame_valid & ~frame_ready;
        end
    end

endmodule

// File: tb/tb_lpgbt_fe_tx_gearbox.sv
// tb/tb_lpgbt_fe_tx_gearbox.sv - directed self-checking bench for lpgbt_fe_tx_gearbox
module tb_lpgbt_fe_tx_gearbox;

    localparam logic [31:0] IDLE = 32'hAAAA_AAAA;

    logic         clock = 1'b0;
    logic         reset;
    logic [255:0] frame_in;
    logic         frame_valid;
    logic         frame_ready;
    logic         word_ce;
    logic [31:0]  word_out;
    logic         word_first;
    logic         underrun;
    logic         overrun;

    int n_checks = 0;
    int n_pass   = 0;
    int flag_err = 0;

    always #5 clock = ~clock;

    lpgbt_fe_tx_gearbox dut (
        .clock       (clock),
        .reset       (reset),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .word_ce     (word_ce),
        .word_out    (word_out),
        .word_first  (word_first),
        .underrun    (underrun),
        .overrun     (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [255:0] mk(input logic [31:0] base);
        logic [255:0] f;
        for (int k = 0; k < 8; k++) f[k*32 +: 32] = base + 32'(k);
        return f;
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [255:0] fa;
        logic [255:0] fb;

        reset = 1'b1; frame_in = '0; frame_valid = 1'b0; word_ce = 1'b0;
        #1;
        chk("ready_in_reset", 32'(frame_ready), 32'd0);
        tick; tick;
        chk("rst_word_out", word_out, IDLE);
        chk("rst_word_first", 32'(word_first), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", 32'(frame_ready), 32'd1);

        // 1: buffered frame of words 0..7
        frame_in = mk(32'h0); frame_valid = 1'b1;
        tick;
        frame_valid = 1'b0;
        chk("t1_ready_full", 32'(frame_ready), 32'd0);
        word_ce = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick;
            chk($sformatf("t1_word%0d", k), word_out, 32'(k));
            chk($sformatf("t1_first%0d", k), 32'(word_first), 32'(k == 0));
            chk($sformatf("t1_flags%0d", k), {30'd0, underrun, overrun}, 32'd0);
        end
        word_ce = 1'b0;
        tick;
        chk("t1_first_idle", 32'(word_first), 32'd0);
        chk("t1_word_hold", word_out, 32'd7);

        // 2: underrun with nothing to send
        for (int k = 0; k < 3; k++) begin
            word_ce = 1'b1;
            tick;
            chk($sformatf("t2_idle%0d", k), word_out, IDLE);
            chk($sformatf("t2_underrun%0d", k), 32'(underrun), 32'd1);
            chk($sformatf("t2_first%0d", k), 32'(word_first), 32'd0);
            word_ce = 1'b0;
            tick;
            chk($sformatf("t2_underrun_low%0d", k), 32'(underrun), 32'd0);
        end

        // 3: overrun, buffered frame A survives, B dropped
        fa = mk(32'hA000_0000); fb = mk(32'hB000_0000);
        frame_in = fa; frame_valid = 1'b1;
        tick;
        frame_in = fb;
        chk("t3_ready_full", 32'(frame_ready), 32'd0);
        tick;
        frame_valid = 1'b0;
        chk("t3_overrun", 32'(overrun), 32'd1);
        tick;
        chk("t3_overrun_low", 32'(overrun), 32'd0);
        word_ce = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick;
            chk($sformatf("t3_word%0d", k), word_out, 32'hA000_0000 + 32'(k));
        end
        word_ce = 1'b0;
        tick;
        chk("t3_ready_empty", 32'(frame_ready), 32'd1);

        // 4: cut-through at an empty slot start
        fa = mk(32'hC000_0000);
        frame_in = fa; frame_valid = 1'b1; word_ce = 1'b1;
        tick;
        frame_valid = 1'b0;
        chk("t4_word0", word_out, 32'hC000_0000);
        chk("t4_first", 32'(word_first), 32'd1);
        chk("t4_no_underrun", 32'(underrun), 32'd0);
        chk("t4_ready", 32'(frame_ready), 32'd1);
        for (int k = 1; k < 8; k++) begin
            tick;
            chk($sformatf("t4_word%0d", k), word_out, 32'hC000_0000 + 32'(k));
        end

        // 5: 100 back-to-back frames, word_ce every cycle
        for (int j = 0; j < 800; j++) begin
            frame_valid = (j % 8 == 0);
            frame_in    = mk(32'h1000_0000 + 32'((j / 8) * 256));
            tick;
            chk($sformatf("t5_word%0d", j), word_out, 32'h1000_0000 + 32'((j / 8) * 256 + j % 8));
            if (underrun || overrun || (word_first != (j % 8 == 0))) flag_err++;
        end
        frame_valid = 1'b0;
        chk("t5_flags", 32'(flag_err), 32'd0);

        // 6: reset at cnt=4 discards in-flight and buffered frames
        frame_in = mk(32'hD000_0000); frame_valid = 1'b1;
        tick;
        chk("t6_d0", word_out, 32'hD000_0000);
        frame_in = mk(32'hE000_0000);
        tick;
        frame_valid = 1'b0;
        chk("t6_d1", word_out, 32'hD000_0001);
        tick; tick;
        chk("t6_d3", word_out, 32'hD000_0003);
        word_ce = 1'b0; reset = 1'b1;
        #1;
        chk("t6_ready_in_reset", 32'(frame_ready), 32'd0);
        tick;
        chk("t6_word_reset", word_out, IDLE);
        reset = 1'b0; word_ce = 1'b1;
        tick;
        chk("t6_idle_after", word_out, IDLE);
        chk("t6_underrun_after", 32'(underrun), 32'd1);
        frame_in = mk(32'hF000_0000); frame_valid = 1'b1;
        tick;
        frame_valid = 1'b0; word_ce = 1'b0;
        chk("t6_f0", word_out, 32'hF000_0000);
        chk("t6_f_first", 32'(word_first), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
